// File: rtl/commit_trace_queue.sv
`default_nettype none
// ============================================================================
// Module   : commit_trace_queue
// Purpose  : Collects up to three commit events per cycle (register
//            writeback, store, control-flow resolution) into a circular
//            trace FIFO and presents the oldest record through a
//            valid/ready handshake. Events that do not fit are dropped and
//            reported through a sticky overflow flag and a drop counter.
// Ports    : clk, reset_n (async, active-low)
//            wb_*  : writeback commit  (rd==0 writes are not traced)
//            st_*  : store commit
//            cf_*  : branch/jump resolution
//            flush : synchronous queue clear
//            trc_* : head record + valid/ready handshake
//            overflow, drop_cnt : loss reporting
// Config   : TRACE_DROP_CNT_EN defined   -> 16-bit saturating drop counter
//            TRACE_DROP_CNT_EN undefined -> drop_cnt tied to zero
// Revision : 1.0 - initial release
// ============================================================================
module commit_trace_queue #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_instr,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        st_valid,
    input  logic [31:0] st_pc,
    input  logic [31:0] st_instr,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic        cf_valid,
    input  logic [31:0] cf_pc,
    input  logic [31:0] cf_instr,
    input  logic        cf_taken,
    input  logic [31:0] cf_target,
    input  logic        flush,
    output logic        trc_valid,
    input  logic        trc_ready,
    output logic [1:0]  trc_type,
    output logic [31:0] trc_pc,
    output logic [31:0] trc_instr,
    output logic [4:0]  trc_rd,
    output logic [31:0] trc_value,
    output logic [31:0] trc_addr,
    output logic        overflow,
    output logic [15:0] drop_cnt
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH_CW = c_CW'(DEPTH);

    localparam logic [1:0] c_T_REG   = 2'd0;
    localparam logic [1:0] c_T_STORE = 2'd1;
    localparam logic [1:0] c_T_TAKEN = 2'd2;
    localparam logic [1:0] c_T_NTKN  = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] value;
        logic [31:0] addr;
    } rec_t;

    // Entry storage is deliberately not reset: validity is tracked by count.
    rec_t            mem_q [DEPTH];

    logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CW-1:0] count_q,  count_d;
    logic            overflow_q, overflow_d;

    logic [2:0]      w_ev_valid;
    rec_t            w_rec    [3];
    logic            w_accept [3];
    logic [c_AW-1:0] w_slot   [3];
    logic [c_CW-1:0] w_free;
    logic [c_CW-1:0] w_n_ev;
    logic [c_CW-1:0] w_n_push;
    logic [c_CW-1:0] w_n_drop;
    logic            w_pop;

    // Build the three candidate records and pack accepted ones into
    // consecutive slots, oldest instruction (WB) first.
    always_comb begin
        w_ev_valid = {cf_valid, st_valid, wb_valid && (wb_rd != 5'd0)};
        w_rec[0]   = '{kind: c_T_REG, pc: wb_pc, instr: wb_instr, rd: wb_rd,
                       value: wb_data, addr: 32'd0};
        w_rec[1]   = '{kind: c_T_STORE, pc: st_pc, instr: st_instr, rd: 5'd0,
                       value: st_data, addr: st_addr};
        w_rec[2]   = '{kind: (cf_taken ? c_T_TAKEN : c_T_NTKN), pc: cf_pc,
                       instr: cf_instr, rd: 5'd0,
                       value: (cf_taken ? cf_target : 32'd0), addr: 32'd0};
        // Space comes from the registered count only; a same-cycle pop
        // does not make room for a push.
        w_free   = c_DEPTH_CW - count_q;
        w_n_ev   = '0;
        w_n_push = '0;
        for (int e = 0; e < 3; e++) begin
            w_accept[e] = 1'b0;
            w_slot[e]   = wr_ptr_q + w_n_push[c_AW-1:0];
            if (w_ev_valid[e]) begin
                w_n_ev = w_n_ev + 1'b1;
                if (w_n_push < w_free) begin
                    w_accept[e] = 1'b1;
                    w_n_push    = w_n_push + 1'b1;
                end
            end
        end
        w_n_drop = w_n_ev - w_n_push;
        w_pop    = (count_q != '0) && trc_ready;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + w_n_push[c_AW-1:0];
        rd_ptr_d   = rd_ptr_q + {{(c_AW-1){1'b0}}, w_pop};
        count_d    = count_q + w_n_push - {{(c_CW-1){1'b0}}, w_pop};
        overflow_d = overflow_q;
        if (flush) begin
            // Same-cycle pushes/pops vanish and are not treated as losses.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (w_n_drop != '0) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < 3; e++) begin
            if (w_accept[e] && !flush) begin
                mem_q[w_slot[e]] <= w_rec[e];
            end
        end
    end

`ifdef TRACE_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] w_drop_sum;

    always_comb begin
        w_drop_sum = {1'b0, drop_cnt_q} + 17'(w_n_drop);
        drop_cnt_d = drop_cnt_q;
        if (!flush) begin
            drop_cnt_d = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'd0;
`endif

    assign trc_valid = (count_q != '0);
    assign trc_type  = mem_q[rd_ptr_q].kind;
    assign trc_pc    = mem_q[rd_ptr_q].pc;
    assign trc_instr = mem_q[rd_ptr_q].instr;
    assign trc_rd    = mem_q[rd_ptr_q].rd;
    assign trc_value = mem_q[rd_ptr_q].value;
    assign trc_addr  = mem_q[rd_ptr_q].addr;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_trace_queue
// Purpose  : Directed self-checking bench for commit_trace_queue (DEPTH=16).
//            Honours TRACE_DROP_CNT_EN for the expected drop counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_commit_trace_queue;

`ifdef TRACE_DROP_CNT_EN
    localparam bit c_DC_EN = 1'b1;
`else
    localparam bit c_DC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_valid, st_valid, cf_valid, cf_taken, flush, trc_ready;
    logic [31:0] wb_pc, wb_instr, wb_data;
    logic [4:0]  wb_rd;
    logic [31:0] st_pc, st_instr, st_addr, st_data;
    logic [31:0] cf_pc, cf_instr, cf_target;
    logic        trc_valid, overflow;
    logic [1:0]  trc_type;
    logic [31:0] trc_pc, trc_instr, trc_value, trc_addr;
    logic [4:0]  trc_rd;
    logic [15:0] drop_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    commit_trace_queue #(.DEPTH(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .st_valid(st_valid), .st_pc(st_pc), .st_instr(st_instr),
        .st_addr(st_addr), .st_data(st_data),
        .cf_valid(cf_valid), .cf_pc(cf_pc), .cf_instr(cf_instr),
        .cf_taken(cf_taken), .cf_target(cf_target),
        .flush(flush),
        .trc_valid(trc_valid), .trc_ready(trc_ready),
        .trc_type(trc_type), .trc_pc(trc_pc), .trc_instr(trc_instr),
        .trc_rd(trc_rd), .trc_value(trc_value), .trc_addr(trc_addr),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 0; st_valid = 0; cf_valid = 0; cf_taken = 0; flush = 0;
        wb_pc = 0; wb_instr = 0; wb_rd = 0; wb_data = 0;
        st_pc = 0; st_instr = 0; st_addr = 0; st_data = 0;
        cf_pc = 0; cf_instr = 0; cf_target = 0;
    endtask

    task automatic push_wb(input logic [31:0] pc, input logic [4:0] rd,
                           input logic [31:0] data);
        wb_valid = 1; wb_pc = pc; wb_instr = 32'h13; wb_rd = rd; wb_data = data;
        step();
        wb_valid = 0;
    endtask

    initial begin
        idle_inputs();
        trc_ready = 0;
        reset_n   = 0;
        #2;
        check("rst_valid", {31'd0, trc_valid}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_drop", {16'd0, drop_cnt}, 32'd0);
        step(); step();
        reset_n = 1;
        step();

        // Single writeback record, then empty.
        trc_ready = 1;
        wb_valid = 1; wb_pc = 32'h100; wb_instr = 32'h00500093;
        wb_rd = 5'd1; wb_data = 32'd5;
        step();
        wb_valid = 0;
        check("single_valid", {31'd0, trc_valid}, 32'd1);
        check("single_type", {30'd0, trc_type}, 32'd0);
        check("single_pc", trc_pc, 32'h100);
        check("single_instr", trc_instr, 32'h00500093);
        check("single_rd", {27'd0, trc_rd}, 32'd1);
        check("single_value", trc_value, 32'd5);
        check("single_addr", trc_addr, 32'd0);
        step();
        check("single_empty", {31'd0, trc_valid}, 32'd0);

        // Three events in one cycle drain in WB, ST, CF order.
        wb_valid = 1; wb_pc = 32'h20; wb_rd = 5'd3; wb_data = 32'h11;
        st_valid = 1; st_pc = 32'h24; st_addr = 32'h1000; st_data = 32'hDEADBEEF;
        cf_valid = 1; cf_pc = 32'h28; cf_taken = 1; cf_target = 32'h40;
        step();
        idle_inputs();
        check("tri0_pc", trc_pc, 32'h20);
        check("tri0_type", {30'd0, trc_type}, 32'd0);
        check("tri0_value", trc_value, 32'h11);
        step();
        check("tri1_pc", trc_pc, 32'h24);
        check("tri1_type", {30'd0, trc_type}, 32'd1);
        check("tri1_rd", {27'd0, trc_rd}, 32'd0);
        check("tri1_value", trc_value, 32'hDEADBEEF);
        check("tri1_addr", trc_addr, 32'h1000);
        step();
        check("tri2_pc", trc_pc, 32'h28);
        check("tri2_type", {30'd0, trc_type}, 32'd2);
        check("tri2_value", trc_value, 32'h40);
        step();
        check("tri_empty", {31'd0, trc_valid}, 32'd0);

        // Not-taken branch record; rd==0 writeback is filtered out.
        cf_valid = 1; cf_pc = 32'h30; cf_taken = 0; cf_target = 32'h50;
        wb_valid = 1; wb_pc = 32'h2C; wb_rd = 5'd0; wb_data = 32'h77;
        step();
        idle_inputs();
        check("ntkn_pc", trc_pc, 32'h30);
        check("ntkn_type", {30'd0, trc_type}, 32'd3);
        check("ntkn_value", trc_value, 32'd0);
        step();
        check("rd0_filtered", {31'd0, trc_valid}, 32'd0);
        check("no_ovf_yet", {31'd0, overflow}, 32'd0);

        // Fill 15, then a 3-event cycle: only WB fits.
        trc_ready = 0;
        for (int i = 0; i < 15; i++) push_wb(32'h200 + 32'(4 * i), 5'd2, 32'(i));
        check("fill15_ovf", {31'd0, overflow}, 32'd0);
        wb_valid = 1; wb_pc = 32'h300; wb_rd = 5'd4; wb_data = 32'hAA;
        st_valid = 1; st_pc = 32'h304; st_addr = 32'h2000; st_data = 32'hBB;
        cf_valid = 1; cf_pc = 32'h308; cf_taken = 1; cf_target = 32'h500;
        step();
        idle_inputs();
        check("over_ovf", {31'd0, overflow}, 32'd1);
        check("over_drop", {16'd0, drop_cnt}, c_DC_EN ? 32'd2 : 32'd0);
        check("over_valid", {31'd0, trc_valid}, 32'd1);
        check("over_head", trc_value, 32'd0);

        // Full with a pop: pushed store is still dropped.
        trc_ready = 1;
        st_valid = 1; st_pc = 32'h400; st_addr = 32'h3000; st_data = 32'hCC;
        step();
        st_valid = 0;
        check("full_drop", {16'd0, drop_cnt}, c_DC_EN ? 32'd3 : 32'd0);
        check("full_head", trc_value, 32'd1);
        for (int i = 0; i < 14; i++) step();
        check("last_valid", {31'd0, trc_valid}, 32'd1);
        check("last_value", trc_value, 32'hAA);
        check("last_pc", trc_pc, 32'h300);
        step();
        check("drain_empty", {31'd0, trc_valid}, 32'd0);

        // Flush with 8 queued and a simultaneous push.
        trc_ready = 0;
        for (int i = 0; i < 8; i++) push_wb(32'h600 + 32'(4 * i), 5'd5, 32'h100 + 32'(i));
        flush = 1;
        wb_valid = 1; wb_pc = 32'h700; wb_rd = 5'd6; wb_data = 32'h999;
        step();
        idle_inputs();
        check("flush_valid", {31'd0, trc_valid}, 32'd0);
        check("flush_drop", {16'd0, drop_cnt}, c_DC_EN ? 32'd3 : 32'd0);
        check("flush_ovf", {31'd0, overflow}, 32'd1);
        push_wb(32'h800, 5'd7, 32'h1234);
        check("post_flush_val", trc_value, 32'h1234);

        // Asynchronous reset mid-operation with 5 entries queued.
        for (int i = 0; i < 4; i++) push_wb(32'h900 + 32'(4 * i), 5'd8, 32'(i));
        #2;
        reset_n = 0;
        #1;
        check("arst_valid", {31'd0, trc_valid}, 32'd0);
        check("arst_ovf", {31'd0, overflow}, 32'd0);
        check("arst_drop", {16'd0, drop_cnt}, 32'd0);
        wb_valid = 1; wb_pc = 32'hA00; wb_rd = 5'd9; wb_data = 32'h55;
        step(); step();
        check("arst_ignore", {31'd0, trc_valid}, 32'd0);
        idle_inputs();
        reset_n = 1;
        step();
        check("arst_release", {31'd0, trc_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
